// File: rtl/exception_unit.sv
// Exception/interrupt arbiter at the MEM stage.
// Picks the highest-priority cause for the MEM instruction and drives the
// cp0 update strobes combinationally in the take cycle. It then holds
// flush/redirect for FLUSH_CYCLES cycles and waits one SETTLE cycle, so
// cp0 EXL is visible before another take can happen.
//
// mem_exc_flags layout, LSB first:
//   [0] adel_fetch  [1] tlbl_fetch  [2] ri    [3] sys   [4] bp     [5] ov
//   [6] adel_data   [7] ades        [8] tlbl_data [9] tlbs_data [10] tlb_mod
// The named cause list needs eleven bits, so the port is eleven bits wide.
module exception_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] BOOT_BASE    = 32'hBFC00200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delay_slot,
  input  logic [10:0] mem_exc_flags,
  input  logic        mem_tlb_refill,
  input  logic [31:0] mem_fetch_vaddr,
  input  logic [31:0] mem_data_vaddr,
  input  logic        mem_eret,
  input  logic [5:0]  hardware_int_o,
  input  logic [1:0]  software_int_o,
  input  logic [7:0]  interrupt_mask,
  input  logic        allow_int,
  input  logic        int_exl,
  input  logic        boot_exp_vec,
  input  logic        special_int_vec,
  input  logic [19:0] ebase,
  input  logic [31:0] epc,
  output logic        en_exp,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic        exp_bd,
  output logic [31:0] exp_bad_vaddr,
  output logic        exp_badv_we,
  output logic        clean_exl,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, SETTLE = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        flush_q, redirect_q;
  logic [31:0] redirect_pc_q;

  logic        int_req, exc_hit, is_int, is_fetch, is_data, is_tlb;
  logic [4:0]  cause_code;
  logic        take_ok, take_exc, take_eret;
  logic [31:0] vec_base, vec_off, vector, redirect_d;

  assign int_req = allow_int & |({hardware_int_o, software_int_o} & interrupt_mask);

  // Fixed-priority cause selection; interrupts beat every synchronous cause.
  always_comb begin
    exc_hit    = 1'b1;
    is_int     = 1'b0;
    is_fetch   = 1'b0;
    is_data    = 1'b0;
    is_tlb     = 1'b0;
    cause_code = 5'd0;
    if (int_req)                begin is_int = 1'b1; cause_code = 5'd0; end
    else if (mem_exc_flags[0])  begin is_fetch = 1'b1; cause_code = 5'd4; end
    else if (mem_exc_flags[1])  begin is_fetch = 1'b1; is_tlb = 1'b1; cause_code = 5'd2; end
    else if (mem_exc_flags[2])  cause_code = 5'd10;
    else if (mem_exc_flags[3])  cause_code = 5'd8;
    else if (mem_exc_flags[4])  cause_code = 5'd9;
    else if (mem_exc_flags[5])  cause_code = 5'd12;
    else if (mem_exc_flags[6])  begin is_data = 1'b1; cause_code = 5'd4; end
    else if (mem_exc_flags[7])  begin is_data = 1'b1; cause_code = 5'd5; end
    else if (mem_exc_flags[8])  begin is_data = 1'b1; is_tlb = 1'b1; cause_code = 5'd2; end
    else if (mem_exc_flags[9])  begin is_data = 1'b1; is_tlb = 1'b1; cause_code = 5'd3; end
    else if (mem_exc_flags[10]) begin is_data = 1'b1; cause_code = 5'd1; end
    else                        exc_hit = 1'b0;
  end

  // Vector offset: TLB refill outside EXL, special interrupt vector, or general.
  always_comb begin
    if (is_tlb && mem_tlb_refill && !int_exl) vec_off = 32'h0000_0000;
    else if (is_int && special_int_vec)       vec_off = 32'h0000_0200;
    else                                      vec_off = 32'h0000_0180;
  end

  assign vec_base   = boot_exp_vec ? BOOT_BASE : {ebase, 12'h000};
  assign vector     = vec_base + vec_off;

  assign take_ok    = rst && stall && mem_valid && (state_q == IDLE);
  assign take_exc   = take_ok && exc_hit;
  assign take_eret  = take_ok && !exc_hit && mem_eret;
  assign redirect_d = take_exc ? vector : epc;

  assign en_exp        = take_exc;
  assign clean_exl     = take_eret;
  assign exp_code      = take_exc ? cause_code : 5'd0;
  assign exp_bd        = take_exc && mem_in_delay_slot;
  assign exp_epc       = !take_exc ? 32'h0 : (mem_in_delay_slot ? mem_pc - 32'd4 : mem_pc);
  assign exp_badv_we   = take_exc && (is_fetch || is_data);
  assign exp_bad_vaddr = !take_exc ? 32'h0 :
                         is_fetch  ? mem_fetch_vaddr :
                         is_data   ? mem_data_vaddr  : 32'h0;

  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

  // Flush-window FSM; a low stall freezes state, counter and outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'h0;
    end else if (stall) begin
      case (state_q)
        IDLE: if (take_exc || take_eret) begin
          state_q       <= FLUSH;
          cnt_q         <= CNT_INIT;
          flush_q       <= 1'b1;
          redirect_q    <= 1'b1;
          redirect_pc_q <= redirect_d;
        end
        FLUSH: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          state_q    <= SETTLE;
          flush_q    <= 1'b0;
          redirect_q <= 1'b0;
        end
        SETTLE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: a vector table for cause/vector selection plus
// hand sequences for flush timing, stall freeze, reset mid-flush, bubbles
// and SETTLE blocking. Expected redirect PCs go into a queue when a take is
// driven and are compared when flush rises.
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        rst, stall, mem_valid, mem_in_delay_slot, mem_tlb_refill, mem_eret;
  logic [31:0] mem_pc, mem_fetch_vaddr, mem_data_vaddr, epc;
  logic [10:0] mem_exc_flags;
  logic [5:0]  hardware_int_o;
  logic [1:0]  software_int_o;
  logic [7:0]  interrupt_mask;
  logic        allow_int, int_exl, boot_exp_vec, special_int_vec;
  logic [19:0] ebase;
  logic        en_exp, exp_bd, exp_badv_we, clean_exl, flush, redirect;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc, exp_bad_vaddr, redirect_pc;

  int asserts = 0;
  int failures = 0;
  logic [31:0] sb_q[$];
  logic flush_prev = 1'b0;

  exception_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_in_delay_slot(mem_in_delay_slot), .mem_exc_flags(mem_exc_flags),
    .mem_tlb_refill(mem_tlb_refill), .mem_fetch_vaddr(mem_fetch_vaddr),
    .mem_data_vaddr(mem_data_vaddr), .mem_eret(mem_eret),
    .hardware_int_o(hardware_int_o), .software_int_o(software_int_o),
    .interrupt_mask(interrupt_mask), .allow_int(allow_int), .int_exl(int_exl),
    .boot_exp_vec(boot_exp_vec), .special_int_vec(special_int_vec), .ebase(ebase),
    .epc(epc), .en_exp(en_exp), .exp_code(exp_code), .exp_epc(exp_epc), .exp_bd(exp_bd),
    .exp_bad_vaddr(exp_bad_vaddr), .exp_badv_we(exp_badv_we), .clean_exl(clean_exl),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [10:0] flags;
    logic [31:0] pc;
    logic        ds, eret, refill, exl, boot, spec, allow;
    logic [5:0]  hw;
    logic [1:0]  sw;
    logic [7:0]  mask;
    logic [31:0] fva, dva;
    logic [19:0] eb;
    logic [31:0] epcv;
    logic        x_en, x_clean;
    logic [4:0]  x_code;
    logic [31:0] x_epc;
    logic        x_bd, x_we;
    logic [31:0] x_badv, x_rpc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Redirect checker: every flush rise must match the oldest queued take.
  always @(negedge clk) begin
    if (flush && !flush_prev) begin
      if (sb_q.size() == 0) begin
        asserts++;
        failures++;
        $display("FAIL sb_unexpected_flush: got redirect_pc %h expected no take", redirect_pc);
      end else begin
        check("sb_redirect_pc", redirect_pc, sb_q.pop_front());
        check("sb_redirect", {31'b0, redirect}, 32'd1);
      end
    end
    flush_prev <= flush;
  end

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_exc_flags = '0; mem_eret = 1'b0; mem_pc = '0;
    mem_in_delay_slot = 1'b0; mem_tlb_refill = 1'b0; mem_fetch_vaddr = '0;
    mem_data_vaddr = '0; hardware_int_o = '0; software_int_o = '0;
    interrupt_mask = '0; allow_int = 1'b0; int_exl = 1'b0; boot_exp_vec = 1'b0;
    special_int_vec = 1'b0; ebase = 20'h80000; epc = '0; stall = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    mem_valid = v.valid; mem_exc_flags = v.flags; mem_pc = v.pc;
    mem_in_delay_slot = v.ds; mem_eret = v.eret; mem_tlb_refill = v.refill;
    int_exl = v.exl; boot_exp_vec = v.boot; special_int_vec = v.spec;
    allow_int = v.allow; hardware_int_o = v.hw; software_int_o = v.sw;
    interrupt_mask = v.mask; mem_fetch_vaddr = v.fva; mem_data_vaddr = v.dva;
    ebase = v.eb; epc = v.epcv; stall = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_comb(input vec_t v);
    check({v.name, ".en_exp"},    {31'b0, en_exp},      {31'b0, v.x_en});
    check({v.name, ".clean_exl"}, {31'b0, clean_exl},   {31'b0, v.x_clean});
    check({v.name, ".exp_code"},  {27'b0, exp_code},    {27'b0, v.x_code});
    check({v.name, ".exp_epc"},   exp_epc,              v.x_epc);
    check({v.name, ".exp_bd"},    {31'b0, exp_bd},      {31'b0, v.x_bd});
    check({v.name, ".badv_we"},   {31'b0, exp_badv_we}, {31'b0, v.x_we});
    check({v.name, ".bad_vaddr"}, exp_bad_vaddr,        v.x_badv);
  endtask

  initial begin
    vec_t v;
    rst = 1'b0;
    idle_inputs();
    //         name         vld flags    pc            ds ert rf exl bt sp al hw     sw    mask   fva           dva           eb         epc           | en cl code   xepc          bd we badv          rpc
    tbl.push_back('{"ri_boot",    1, 11'h004, 32'h80001000, 0, 0, 0, 0, 1, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h0,        20'h80000, 32'h0,        1, 0, 5'd10, 32'h80001000, 0, 0, 32'h0,        32'hBFC00380});
    tbl.push_back('{"ov_ds",      1, 11'h060, 32'h80002004, 1, 0, 0, 0, 0, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h00000777, 20'h80000, 32'h0,        1, 0, 5'd12, 32'h80002000, 1, 0, 32'h0,        32'h80000180});
    tbl.push_back('{"tlbl_refill",1, 11'h100, 32'h80004000, 0, 0, 1, 0, 0, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h00400010, 20'h80000, 32'h0,        1, 0, 5'd2,  32'h80004000, 0, 1, 32'h00400010, 32'h80000000});
    tbl.push_back('{"eret",       1, 11'h000, 32'h80005000, 0, 1, 0, 0, 0, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h0,        20'h80000, 32'h80003000, 0, 1, 5'd0,  32'h0,        0, 0, 32'h0,        32'h80003000});
    tbl.push_back('{"eret_sys",   1, 11'h008, 32'h80005000, 0, 1, 0, 0, 0, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h0,        20'h80000, 32'h80003000, 1, 0, 5'd8,  32'h80005000, 0, 0, 32'h0,        32'h80000180});
    tbl.push_back('{"fetch_pri",  1, 11'h007, 32'h80000120, 0, 0, 0, 0, 0, 0, 0, 6'h00, 2'h0, 8'h00, 32'h80000123, 32'h0,        20'h80000, 32'h0,        1, 0, 5'd4,  32'h80000120, 0, 1, 32'h80000123, 32'h80000180});
    tbl.push_back('{"tlbl_f_exl", 1, 11'h002, 32'h00001000, 0, 0, 1, 1, 1, 0, 0, 6'h00, 2'h0, 8'h00, 32'h00001000, 32'h0,        20'h80000, 32'h0,        1, 0, 5'd2,  32'h00001000, 0, 1, 32'h00001000, 32'hBFC00380});
    tbl.push_back('{"tlbs_boot",  1, 11'h200, 32'h80006000, 0, 0, 1, 0, 1, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h00500020, 20'h80000, 32'h0,        1, 0, 5'd3,  32'h80006000, 0, 1, 32'h00500020, 32'hBFC00200});
    tbl.push_back('{"tlb_mod",    1, 11'h400, 32'h80007000, 0, 0, 1, 0, 0, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h00600030, 20'h80000, 32'h0,        1, 0, 5'd1,  32'h80007000, 0, 1, 32'h00600030, 32'h80000180});
    tbl.push_back('{"ades",       1, 11'h180, 32'h80008000, 0, 0, 0, 0, 0, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h00000003, 20'h80000, 32'h0,        1, 0, 5'd5,  32'h80008000, 0, 1, 32'h00000003, 32'h80000180});
    tbl.push_back('{"bp_ov",      1, 11'h030, 32'h80009000, 0, 0, 0, 0, 0, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h0,        20'h80000, 32'h0,        1, 0, 5'd9,  32'h80009000, 0, 0, 32'h0,        32'h80000180});
    tbl.push_back('{"sw_int",     1, 11'h004, 32'h8000A000, 0, 0, 0, 0, 0, 0, 1, 6'h00, 2'h1, 8'h01, 32'h0,        32'h0,        20'h80000, 32'h0,        1, 0, 5'd0,  32'h8000A000, 0, 0, 32'h0,        32'h80000180});
    tbl.push_back('{"int_masked", 1, 11'h000, 32'h8000A000, 0, 0, 0, 0, 0, 0, 1, 6'h00, 2'h2, 8'h01, 32'h0,        32'h0,        20'h80000, 32'h0,        0, 0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0});
    tbl.push_back('{"int_disable",1, 11'h000, 32'h8000A000, 0, 0, 0, 0, 0, 0, 0, 6'h3F, 2'h3, 8'hFF, 32'h0,        32'h0,        20'h80000, 32'h0,        0, 0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0});
    tbl.push_back('{"bubble_ri",  0, 11'h004, 32'h8000A000, 0, 0, 0, 0, 0, 0, 0, 6'h00, 2'h0, 8'h00, 32'h0,        32'h0,        20'h80000, 32'h0,        0, 0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0});
    tbl.push_back('{"int_spec_bt",1, 11'h000, 32'h8000B000, 0, 0, 0, 0, 1, 1, 1, 6'h01, 2'h0, 8'h04, 32'h0,        32'h0,        20'h80000, 32'h0,        1, 0, 5'd0,  32'h8000B000, 0, 0, 32'h0,        32'hBFC00400});

    // Reset state: outputs stay cleared even with a cause present under reset.
    @(negedge clk);
    apply(tbl[0]);
    #1;
    check("rst.en_exp", {31'b0, en_exp}, 32'd0);
    check("rst.exp_code", {27'b0, exp_code}, 32'd0);
    @(negedge clk);
    check("rst.flush", {31'b0, flush}, 32'd0);
    check("rst.redirect", {31'b0, redirect}, 32'd0);
    check("rst.redirect_pc", redirect_pc, 32'd0);

    // Table: each vector from a clean reset, then wait out flush + settle.
    foreach (tbl[i]) begin
      do_reset();
      @(negedge clk);
      apply(tbl[i]);
      #1 check_comb(tbl[i]);
      if (tbl[i].x_en || tbl[i].x_clean) sb_q.push_back(tbl[i].x_rpc);
      @(posedge clk);
      #1 idle_inputs();
      repeat (5) @(posedge clk);
    end

    // Flush timing: two cycles of flush/redirect, then cleared.
    do_reset();
    @(negedge clk);
    apply(tbl[0]);
    sb_q.push_back(32'hBFC00380);
    @(posedge clk);
    #1 idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("timing.flush_n%0d", k), {31'b0, flush}, {31'b0, k < 3});
      check($sformatf("timing.redirect_n%0d", k), {31'b0, redirect}, {31'b0, k < 3});
      if (k < 3) check($sformatf("timing.rpc_n%0d", k), redirect_pc, 32'hBFC00380);
    end
    repeat (3) @(posedge clk);

    // Pending interrupt waits through bubbles, taken on first valid cycle.
    do_reset();
    @(negedge clk);
    allow_int = 1'b1; hardware_int_o = 6'b100000; interrupt_mask = 8'h80;
    special_int_vec = 1'b1; mem_pc = 32'h8000C000;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("bubble.en_exp_%0d", k), {31'b0, en_exp}, 32'd0);
      @(negedge clk);
    end
    check("bubble.flush", {31'b0, flush}, 32'd0);
    mem_valid = 1'b1;
    #1;
    check("int.en_exp", {31'b0, en_exp}, 32'd1);
    check("int.exp_code", {27'b0, exp_code}, 32'd0);
    check("int.exp_epc", exp_epc, 32'h8000C000);
    sb_q.push_back(32'h80000200);
    @(posedge clk);
    #1 idle_inputs();
    repeat (5) @(posedge clk);

    // Stall freezes the flush window; counter resumes where it stopped.
    do_reset();
    @(negedge clk);
    apply(tbl[0]);
    sb_q.push_back(32'hBFC00380);
    @(posedge clk);
    #1 idle_inputs();
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall.flush_%0d", k), {31'b0, flush}, 32'd1);
    end
    stall = 1'b1;
    @(negedge clk);
    check("stall.resume_flush", {31'b0, flush}, 32'd1);
    @(negedge clk);
    check("stall.end_flush", {31'b0, flush}, 32'd0);
    repeat (3) @(posedge clk);

    // Reset mid-flush clears outputs and returns to IDLE.
    do_reset();
    @(negedge clk);
    apply(tbl[0]);
    sb_q.push_back(32'hBFC00380);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid.flush", {31'b0, flush}, 32'd0);
    check("rstmid.redirect", {31'b0, redirect}, 32'd0);
    check("rstmid.redirect_pc", redirect_pc, 32'd0);
    rst = 1'b1;
    apply(tbl[0]);
    #1 check("rstmid.idle_take", {31'b0, en_exp}, 32'd1);
    sb_q.push_back(32'hBFC00380);
    @(posedge clk);
    #1 idle_inputs();
    repeat (5) @(posedge clk);

    // Held cause: blocked through FLUSH and SETTLE, retaken once IDLE.
    do_reset();
    @(negedge clk);
    v = tbl[0];
    apply(v);
    #1 check("settle.first_take", {31'b0, en_exp}, 32'd1);
    sb_q.push_back(32'hBFC00380);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1 check($sformatf("settle.en_exp_n%0d", k), {31'b0, en_exp}, {31'b0, k == 4});
      if (k == 3) check("settle.flush_off", {31'b0, flush}, 32'd0);
      if (k == 4) sb_q.push_back(32'hBFC00380);
    end
    @(posedge clk);
    #1 idle_inputs();
    repeat (5) @(posedge clk);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
